dmem_port_ctrl: RTL and testbench

DMEM_PORT_CTRL -- requirements
Module: dmem_port_ctrl

---
 rtl/dmem_port_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: arbitrates a core (byte/half/word) and a loader (word) port onto one
// read-first byte-write BRAM port; four-state FSM with fully registered outputs.
module dmem_port_ctrl #(
  parameter int ADDR_WIDTH   = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [1:0]            c_size,
  input  logic                  c_unsigned,
  input  logic [ADDR_WIDTH+1:0] c_addr,
  input  logic [31:0]           c_wdata,
  output logic                  c_ack,
  output logic                  c_err,
  output logic [31:0]           c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_ack,
  output logic [31:0]           l_rdata,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  gnt_l_q, gnt_l_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic                  c_ack_q, c_ack_d;
  logic                  c_err_q, c_err_d;
  logic [31:0]           c_rdata_q, c_rdata_d;
  logic                  l_ack_q, l_ack_d;
  logic [31:0]           l_rdata_q, l_rdata_d;
  logic                  bram_en_q, bram_en_d;
  logic [3:0]            bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]           bram_din_q, bram_din_d;

  logic        c_bad, starved, grant_l;
  logic [3:0]  st_we;
  logic [31:0] st_din, ld_fmt;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign c_bad   = (c_size == 2'b11) || (c_size == 2'b01 && c_addr[0]) ||
                   (c_size == 2'b10 && c_addr[1:0] != 2'b00);
  assign starved = starve_cnt_q == SMAX;
  assign grant_l = l_req && (!c_req || starved);
  assign st_we   = c_size == 2'b00 ? 4'b0001 << c_addr[1:0] :
                   c_size == 2'b01 ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_din  = c_size == 2'b00 ? {4{c_wdata[7:0]}} :
                   c_size == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
  assign b_sel   = bram_dout[{off_q, 3'b000} +: 8];
  assign h_sel   = off_q[1] ? bram_dout[31:16] : bram_dout[15:0];
  assign ld_fmt  = size_q == 2'b00 ? {{24{~uns_q & b_sel[7]}}, b_sel} :
                   size_q == 2'b01 ? {{16{~uns_q & h_sel[15]}}, h_sel} : bram_dout;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    gnt_l_d      = gnt_l_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    c_ack_d      = 1'b0;
    c_err_d      = 1'b0;
    c_rdata_d    = c_rdata_q;
    l_ack_d      = 1'b0;
    l_rdata_d    = l_rdata_q;
    bram_en_d    = 1'b0;
    bram_we_d    = 4'b0000;
    bram_addr_d  = bram_addr_q;
    bram_din_d   = bram_din_q;
    case (state_q)
      IDLE: if (c_req || l_req) begin
        gnt_l_d = grant_l;
        if (grant_l) begin
          starve_cnt_d = '0;
          we_d         = l_we;
          bram_en_d    = 1'b1;
          bram_we_d    = {4{l_we}};
          bram_addr_d  = l_addr;
          bram_din_d   = l_wdata;
          state_d      = ISSUE;
        end else begin
          // erroring core requests still count against the waiting loader
          starve_cnt_d = (l_req && !starved) ? starve_cnt_q + SW'(1) : starve_cnt_q;
          we_d         = c_we;
          size_d       = c_size;
          uns_d        = c_unsigned;
          off_d        = c_addr[1:0];
          if (c_bad) begin
            c_ack_d   = 1'b1;
            c_err_d   = 1'b1;
            c_rdata_d = '0;
            state_d   = DONE;
          end else begin
            bram_en_d   = 1'b1;
            bram_we_d   = c_we ? st_we : 4'b0000;
            bram_addr_d = c_addr[ADDR_WIDTH+1:2];
            bram_din_d  = st_din;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = DONE;
        if (gnt_l_q) begin
          l_ack_d   = 1'b1;
          l_rdata_d = we_q ? 32'd0 : bram_dout;
        end else begin
          c_ack_d   = 1'b1;
          c_rdata_d = we_q ? 32'd0 : ld_fmt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      gnt_l_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      c_ack_q      <= 1'b0;
      c_err_q      <= 1'b0;
      c_rdata_q    <= '0;
      l_ack_q      <= 1'b0;
      l_rdata_q    <= '0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 4'b0000;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      gnt_l_q      <= gnt_l_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      c_ack_q      <= c_ack_d;
      c_err_q      <= c_err_d;
      c_rdata_q    <= c_rdata_d;
      l_ack_q      <= l_ack_d;
      l_rdata_q    <= l_rdata_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_din_q   <= bram_din_d;
    end
  end

  assign c_ack     = c_ack_q;
  assign c_err     = c_err_q;
  assign c_rdata   = c_rdata_q;
  assign l_ack     = l_ack_q;
  assign l_rdata   = l_rdata_q;
  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb_dmem_port_ctrl: directed vectors against dmem_port_ctrl with a read-first
// byte-write BRAM model; expected values are hand-computed constants.
module tb_dmem_port_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0, c_unsigned = 1'b0;
  logic [1:0]    c_size = 2'b00;
  logic [AW+1:0] c_addr = '0;
  logic [31:0]   c_wdata = '0;
  logic          c_ack, c_err;
  logic [31:0]   c_rdata;
  logic          l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [31:0]   l_wdata = '0;
  logic          l_ack;
  logic [31:0]   l_rdata;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout = '0;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            errors = 0, checks = 0;
  logic          en_seen;
  logic [3:0]    s_we;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_din;

  always #5 clk = ~clk;

  dmem_port_ctrl #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always @(posedge clk) if (bram_en) begin
    bram_dout <= mem[bram_addr];
    for (int i = 0; i < 4; i++) if (bram_we[i]) mem[bram_addr][i*8 +: 8] <= bram_din[i*8 +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic watch_bram();
    if (bram_en) begin
      en_seen = 1'b1;
      s_we    = bram_we;
      s_addr  = bram_addr;
      s_din   = bram_din;
    end
  endtask

  task automatic core_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    c_req = 1'b1; c_we = we; c_size = sz; c_unsigned = uns; c_addr = a; c_wdata = wd;
    lat = 0; rd = 'x; err = 1'bx; en_seen = 1'b0; s_we = 'x; s_addr = 'x; s_din = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      watch_bram();
      if (c_ack) begin
        lat = n; rd = c_rdata; err = c_err;
        check("c_excl_l_ack", {31'd0, l_ack}, 32'd0);
        break;
      end
    end
    @(negedge clk);
    c_req = 1'b0;
  endtask

  task automatic ldr_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    l_req = 1'b1; l_we = we; l_addr = a; l_wdata = wd;
    lat = 0; rd = 'x; en_seen = 1'b0; s_we = 'x; s_addr = 'x; s_din = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      watch_bram();
      if (l_ack) begin
        lat = n; rd = l_rdata;
        check("l_excl_c_ack", {31'd0, c_ack}, 32'd0);
        break;
      end
    end
    @(negedge clk);
    l_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err, both, any_ack;
    int          lat, k, t0, t1;
    logic [9:0]  order;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c_ack", {31'd0, c_ack}, 32'd0);
    check("rst_l_ack", {31'd0, l_ack}, 32'd0);
    check("rst_c_err", {31'd0, c_err}, 32'd0);
    check("rst_rdata", c_rdata | l_rdata, 32'd0);
    check("rst_bram", {27'd0, bram_en, bram_we}, 32'd0);
    check("rst_addr_din", {24'd0, bram_addr} | bram_din, 32'd0);
    @(negedge clk) reset = 1'b1;

    core_op(1'b1, 2'b00, 1'b0, 10'h006, 32'h0000_00AB, rd, err, lat);
    check("sb_lat", lat, 3);
    check("sb_en", {31'd0, en_seen}, 32'd1);
    check("sb_we", {28'd0, s_we}, 32'h4);
    check("sb_addr", {24'd0, s_addr}, 32'd1);
    check("sb_din", s_din, 32'hABAB_ABAB);
    check("sb_err", {31'd0, err}, 32'd0);
    check("sb_rdata", rd, 32'd0);
    check("sb_mem", mem[1], 32'h00AB_0000);

    mem[1] = 32'h80FF_1234;
    core_op(1'b0, 2'b00, 1'b0, 10'h007, 32'd0, rd, err, lat);
    check("lb_s_7", rd, 32'hFFFF_FF80);
    check("lb_lat", lat, 3);
    check("lb_we0", {28'd0, s_we}, 32'd0);
    core_op(1'b0, 2'b01, 1'b1, 10'h006, 32'd0, rd, err, lat);
    check("lh_u_6", rd, 32'h0000_80FF);
    core_op(1'b0, 2'b01, 1'b0, 10'h006, 32'd0, rd, err, lat);
    check("lh_s_6", rd, 32'hFFFF_80FF);
    core_op(1'b0, 2'b01, 1'b0, 10'h004, 32'd0, rd, err, lat);
    check("lh_s_4", rd, 32'h0000_1234);
    core_op(1'b0, 2'b00, 1'b1, 10'h005, 32'd0, rd, err, lat);
    check("lb_u_5", rd, 32'h0000_0012);

    core_op(1'b1, 2'b01, 1'b0, 10'h006, 32'h1234_5678, rd, err, lat);
    check("sh_we", {28'd0, s_we}, 32'hC);
    check("sh_din", s_din, 32'h5678_5678);
    check("sh_mem", mem[1], 32'h5678_1234);
    core_op(1'b1, 2'b10, 1'b0, 10'h008, 32'hCAFE_F00D, rd, err, lat);
    check("sw_we", {28'd0, s_we}, 32'hF);
    check("sw_mem", mem[2], 32'hCAFE_F00D);
    core_op(1'b1, 2'b00, 1'b0, 10'h00B, 32'h0000_01FF, rd, err, lat);
    check("sb3_we", {28'd0, s_we}, 32'h8);
    check("sb3_mem", mem[2], 32'hFFFE_F00D);
    core_op(1'b0, 2'b10, 1'b0, 10'h004, 32'd0, rd, err, lat);
    check("lw_4", rd, 32'h5678_1234);

    core_op(1'b0, 2'b10, 1'b0, 10'h002, 32'd0, rd, err, lat);
    check("ew_err", {31'd0, err}, 32'd1);
    check("ew_rdata", rd, 32'd0);
    check("ew_lat", lat, 1);
    check("ew_no_en", {31'd0, en_seen}, 32'd0);
    @(posedge clk); #1;
    check("ew_ack_drop", {30'd0, c_ack, c_err}, 32'd0);
    core_op(1'b0, 2'b11, 1'b0, 10'h000, 32'd0, rd, err, lat);
    check("e11_err", {31'd0, err}, 32'd1);
    core_op(1'b1, 2'b01, 1'b0, 10'h005, 32'hFFFF_FFFF, rd, err, lat);
    check("eh_err", {31'd0, err}, 32'd1);
    check("eh_no_en", {31'd0, en_seen}, 32'd0);
    check("eh_mem", mem[1], 32'h5678_1234);

    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 10'h000;
    l_req = 1'b1; l_we = 1'b0; l_addr = 8'd0;
    order = '0; k = 0; both = 1'b0; t0 = 0; t1 = 0;
    for (int cyc = 0; cyc < 100 && k < 10; cyc++) begin
      @(posedge clk); #1;
      both |= c_ack & l_ack;
      if (c_ack || l_ack) begin
        order = {order[8:0], l_ack};
        if (k == 0) t0 = cyc;
        if (k == 1) t1 = cyc;
        k++;
      end
    end
    @(negedge clk);
    c_req = 1'b0; l_req = 1'b0;
    check("arb_count", k, 10);
    check("arb_order", {22'd0, order}, 32'b00_0010_0001);
    check("arb_spacing", t1 - t0, 4);
    check("arb_excl", {31'd0, both}, 32'd0);

    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 10'h004;
    l_req = 1'b1; l_we = 1'b0; l_addr = 8'd0;
    @(posedge clk); #1;
    check("rw_issue_en", {31'd0, bram_en}, 32'd1);
    check("rw_starve1", {29'd0, dut.starve_cnt_q}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rw_en", {31'd0, bram_en}, 32'd0);
    check("rw_starve0", {29'd0, dut.starve_cnt_q}, 32'd0);
    any_ack = 1'b0;
    @(negedge clk);
    c_req = 1'b0; l_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_ack |= c_ack | l_ack;
    end
    check("rw_no_ack", {31'd0, any_ack}, 32'd0);
    @(negedge clk) reset = 1'b1;

    ldr_op(1'b1, 8'd5, 32'hDEAD_BEEF, rd, lat);
    check("ls_lat", lat, 3);
    check("ls_we", {28'd0, s_we}, 32'hF);
    check("ls_addr", {24'd0, s_addr}, 32'd5);
    check("ls_rdata", rd, 32'd0);
    check("ls_mem", mem[5], 32'hDEAD_BEEF);
    ldr_op(1'b0, 8'd5, 32'd0, rd, lat);
    check("ll_rdata", rd, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
